// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the jacaranda-8 UART transmitter:
//                FSM state encoding, parity_mode codes and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DIV_W  = 32;

  // parity_mode codes; 2'd3 also means "no parity"
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Transmit FSM state encoding
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_mem
//  Description : Synchronous FIFO, DATA_W x DEPTH, asynchronous active-high
//                reset. Pointers carry one extra wrap bit so full and empty
//                are distinguished without a separate counter.
//  Ports       : clk, reset      - clock, async active-high reset
//                push, wr_data   - write request (ignored when full)
//                pop,  rd_data   - read request (ignored when empty); rd_data
//                                  always shows the head entry
//                count           - occupancy 0..DEPTH
//                full, empty     - status flags
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_mem #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push;
  logic              do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Parametrised UART transmitter with a small transmit FIFO.
//                Frames are START, DATA_W data bits (LSB first), optional
//                parity, then one or two stop bits. Frames are sent
//                back-to-back while tx_en is high and the FIFO has data.
//  Build macro : UART_TX_PARITY_EN - when defined, parity_mode selects
//                even/odd parity; when undefined parity_mode is ignored and
//                no parity bit is ever sent.
//  Ports       : clk, reset      - clock, async active-high reset
//                tx_en           - gates frame starts only
//                clk_count_bit   - clk cycles per bit (0 and 1 mean 1)
//                parity_mode     - 0/3 none, 1 even, 2 odd
//                two_stop        - 1 selects two stop bits
//                wr_data, wr_valid, wr_ready - FIFO write port
//                tx              - registered serial output, idle high
//                busy            - frame in progress or FIFO non-empty
//                fifo_count      - FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W     = DEFAULT_DATA_W,
  parameter  int FIFO_DEPTH = 4,
  parameter  int DIV_W      = DEFAULT_DIV_W,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic [DIV_W-1:0]  clk_count_bit,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int IDX_W = $clog2(DATA_W);

  tx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              stop2_q, stop2_d;      // second stop bit in progress
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              two_stop_q, two_stop_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tx_q, tx_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              pop;
  logic              load;
  logic              bit_end;
  logic              start_ok;

  uart_tx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_valid),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifndef UART_TX_PARITY_EN
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
`endif

  assign wr_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign tx       = tx_q;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop2_d    = stop2_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    div_d      = div_q;
    pop        = 1'b0;
    load       = 1'b0;
    tx_d       = 1'b1;

    // Divisors 0 and 1 both give a single-cycle bit
    bit_end  = (div_q <= DIV_W'(1)) || (baud_q == div_q - DIV_W'(1));
    start_ok = tx_en && !fifo_empty;

    if (state_q != ST_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          load = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
            stop2_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          stop2_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else if (start_ok) begin
            load = 1'b1;             // next frame with no idle gap
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame start: pop the head word and freeze the configuration so that
    // later changes on the config inputs cannot disturb this frame.
    if (load) begin
      pop        = 1'b1;
      state_d    = ST_START;
      baud_d     = '0;
      data_d     = fifo_rd_data;
      two_stop_d = two_stop;
      div_d      = clk_count_bit;
`ifdef UART_TX_PARITY_EN
      par_en_d   = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      par_odd_d  = (parity_mode == PAR_ODD);
`else
      par_en_d   = 1'b0;
      par_odd_d  = 1'b0;
`endif
    end

    // tx follows the next state so the registered line changes together
    // with the state register.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[bit_idx_d];
      ST_PARITY: tx_d = par_odd_q ? ~^data_q : ^data_q;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      div_q      <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop2_q    <= stop2_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. Accepted writes queue
//                an expected frame description; a line monitor decodes every
//                frame seen on tx and compares it, bit time by bit time,
//                against the waveform implied by the queued entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_en = 1'b0;
  logic [31:0] clk_count_bit = 32'd4;
  logic [1:0]  parity_mode = 2'd0;
  logic        two_stop = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         pmode;
    bit         two;
  } exp_t;

  exp_t expq[$];

  uart_tx_fifo #(
    .DATA_W     (8),
    .FIFO_DEPTH (4),
    .DIV_W      (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_en         (tx_en),
    .clk_count_bit (clk_count_bit),
    .parity_mode   (parity_mode),
    .two_stop      (two_stop),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .tx            (tx),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference frame length in clock cycles, straight from the frame format
  function automatic int frame_len(input int div, input int pmode, input bit two);
    int d;
    int p;
    d = (div <= 1) ? 1 : div;
    p = (PAR_BUILT && (pmode == 1 || pmode == 2)) ? 1 : 0;
    return d * (1 + 8 + p + (two ? 2 : 1));
  endfunction

  task automatic push(input logic [7:0] d, output bit acc);
    exp_t e;
    @(negedge clk);
    wr_data  = d;
    wr_valid = 1'b1;
    acc      = wr_ready;
    @(posedge clk);
    if (acc) begin
      e.data  = d;
      e.div   = int'(clk_count_bit);
      e.pmode = int'(parity_mode);
      e.two   = two_stop;
      expq.push_back(e);
    end
    #1;
    wr_valid = 1'b0;
  endtask

  // Counts rising edges until busy drops; optionally changes the divisor
  // after edge number chg_at to prove the running frame ignores it.
  task automatic run_until_idle(input int limit, input int chg_at, input int new_div,
                                output int n, output logic tx_first);
    n = 0;
    tx_first = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) tx_first = tx;
      if (n == chg_at) clk_count_bit = new_div;
    end while (busy && n < limit);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  // Line monitor: decodes each frame and compares with the scoreboard head
  initial begin : monitor
    logic prev;
    exp_t e;
    bit   lv[16];
    int   nb;
    int   de;
    bit   bad;
    bit   aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else if (prev && !tx) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start bit seen with nothing queued");
          prev = tx;
        end else begin
          e  = expq.pop_front();
          de = (e.div <= 1) ? 1 : e.div;
          nb = 0;
          lv[nb] = 1'b0; nb++;
          for (int i = 0; i < 8; i++) begin
            lv[nb] = e.data[i]; nb++;
          end
          if (PAR_BUILT && (e.pmode == 1 || e.pmode == 2)) begin
            lv[nb] = (($countones(e.data) % 2) == 1) ^ (e.pmode == 2); nb++;
          end
          lv[nb] = 1'b1; nb++;
          if (e.two) begin
            lv[nb] = 1'b1; nb++;
          end
          aborted = 1'b0;
          for (int b = 0; b < nb && !aborted; b++) begin
            bad = 1'b0;
            for (int k = 0; k < de; k++) begin
              if (!(b == 0 && k == 0)) @(negedge clk);
              if (reset) begin
                aborted = 1'b1;
                break;
              end
              if (tx !== lv[b]) bad = 1'b1;
            end
            if (!aborted) begin
              checks++;
              if (bad) begin
                errors++;
                $display("FAIL frame_bit%0d data=%h: got a wrong level, required %0d for %0d cycles",
                         b, e.data, lv[b], de);
              end
            end
          end
          prev = aborted ? 1'b1 : tx;
        end
      end else begin
        prev = tx;
      end
    end
  end

  initial begin : stim
    bit   acc;
    int   n;
    logic txf;
    int   low_seen;

    // ---------------- reset state
    repeat (3) @(negedge clk);
    check_eq("reset_tx", tx, 1);
    check_eq("reset_wr_ready", wr_ready, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_fifo_count", fifo_count, 0);
    reset = 1'b0;

    // ---------------- 8N1 basic, latency and length
    tx_en = 1'b1; clk_count_bit = 4; parity_mode = 0; two_stop = 0;
    push(8'hA5, acc);
    check_eq("latency_tx_at_push_edge", tx, 1);
    run_until_idle(200, -1, 0, n, txf);
    check_eq("latency_start_next_edge", txf, 0);
    check_eq("len_8n1_div4", n, frame_len(4, 0, 0) + 1);
    check_eq("busy_after_8n1", busy, 0);

    // ---------------- even and odd parity with two stop bits
    clk_count_bit = 2; parity_mode = 1; two_stop = 1;
    push(8'h07, acc);
    run_until_idle(200, -1, 0, n, txf);
    check_eq("len_even_2stop", n, frame_len(2, 1, 1) + 1);
    parity_mode = 2;
    push(8'h07, acc);
    run_until_idle(200, -1, 0, n, txf);
    check_eq("len_odd_2stop", n, frame_len(2, 2, 1) + 1);

    // ---------------- FIFO full and back-to-back frames
    tx_en = 1'b0; clk_count_bit = 3; parity_mode = 0; two_stop = 0;
    for (int i = 0; i < 4; i++) begin
      push(8'h30 + 8'(i), acc);
      check_eq("push_accepted", acc, 1);
    end
    check_eq("wr_ready_when_full", wr_ready, 0);
    push(8'hEE, acc);
    check_eq("fifth_push_rejected", acc, 0);
    check_eq("fifo_count_full", fifo_count, 4);
    @(negedge clk);
    tx_en = 1'b1;
    run_until_idle(1000, -1, 0, n, txf);
    check_eq("len_back_to_back_x4", n, 4 * frame_len(3, 0, 0) + 1);

    // ---------------- divisor edges and mid-frame divisor change
    clk_count_bit = 0;
    push(8'h5C, acc);
    run_until_idle(200, -1, 0, n, txf);
    check_eq("len_div0", n, 11);
    clk_count_bit = 1;
    push(8'hC3, acc);
    run_until_idle(200, -1, 0, n, txf);
    check_eq("len_div1", n, 11);
    clk_count_bit = 5;
    push(8'h96, acc);
    run_until_idle(400, 7, 2, n, txf);
    check_eq("len_div_change_midframe", n, frame_len(5, 0, 0) + 1);

    // ---------------- reset in the middle of a frame
    tx_en = 1'b0; clk_count_bit = 4;
    for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i), acc);
    @(negedge clk);
    tx_en = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midreset_tx", tx, 1);
    check_eq("midreset_fifo_count", fifo_count, 0);
    check_eq("midreset_busy", busy, 0);
    check_eq("midreset_wr_ready", wr_ready, 1);
    expq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    low_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen++;
    end
    check_eq("after_reset_line_quiet", low_seen, 0);
    check_eq("after_reset_busy", busy, 0);

    // ---------------- tx_en dropped during the third data bit
    tx_en = 1'b0; clk_count_bit = 2;
    for (int i = 0; i < 3; i++) push(8'h11 * 8'(i + 1), acc);
    @(negedge clk);
    tx_en = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    tx_en = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("held_busy", busy, 1);
    check_eq("held_fifo_count", fifo_count, 2);
    check_eq("held_tx_idle", tx, 1);
    repeat (20) @(posedge clk);
    #1;
    check_eq("held_fifo_count_later", fifo_count, 2);
    @(negedge clk);
    tx_en = 1'b1;
    run_until_idle(400, -1, 0, n, txf);
    check_eq("len_resume_x2", n, 2 * frame_len(2, 0, 0) + 1);

    // ---------------- randomized batches
    for (int batch = 0; batch < 8; batch++) begin
      int nw;
      clk_count_bit = $urandom_range(0, 5);
      parity_mode   = 2'($urandom_range(0, 3));
      two_stop      = 1'($urandom_range(0, 1));
      tx_en         = 1'b1;
      nw            = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        push(8'($urandom), acc);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      run_until_idle(3000, -1, 0, n, txf);
    end

    repeat (5) @(posedge clk);
    check_eq("scoreboard_drained", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
